// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: instruction width, the canonical NOP and the
// fetch response record carried from the instruction memory to the core.
package riscv_pkg;

    localparam int ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic            err;
    } resp_t;

    // Instructions are word aligned; any set low address bit is a misaligned fetch.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry in-order FIFO of fetch responses. Reset clears pointers and count;
// the storage slots keep their contents, but dout reads as zero while empty.
module resp_fifo2
    import riscv_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  resp_t      din,
    output resp_t      dout,
    output logic [1:0] count,
    output logic       empty,
    output logic       full
);

    resp_t slot [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  do_push;
    logic  do_pop;

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

    // A push into a full FIFO is honoured only when the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) slot[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : slot[rd_ptr];

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder: accepts PC fetch requests, reads a synchronous
// word array through a one-entry pending stage and returns words in order.
module instr_mem_resp
    import riscv_pkg::*;
#(
    parameter int alen  = 6,
    parameter int ilen  = 32,
    parameter int depth = 2 ** (alen - 2)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [alen-1:0] req_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [ilen-1:0] resp_instr,
    output logic            resp_err,
    input  logic            ld_en,
    input  logic [alen-3:0] ld_addr,
    input  logic [ilen-1:0] ld_data
);

    // Handshakes: a transfer happens at a rising edge where valid && ready.
    // valid never waits on ready; req_ready may depend on resp_ready in the
    // same cycle so a draining consumer keeps one fetch per cycle flowing.

    logic [ilen-1:0] mem [depth];

    logic [alen-3:0] word_idx;
    logic            misaligned;
    logic            accept;
    logic            pop;
    logic            pend_valid;
    resp_t           pend_entry;
    resp_t           head;
    logic [1:0]      fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic [2:0]      occupancy;

    assign word_idx   = req_addr[alen-1:2];
    assign misaligned = is_misaligned(req_addr[1:0]);

    assign pop       = resp_valid && resp_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, pend_valid};
    assign req_ready = !ld_en && ((occupancy < 3'd2) || pop);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // The pending stage always drains into the FIFO on the following edge,
    // so it holds a request for exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pend_valid <= 1'b0;
        else       pend_valid <= accept;
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            pend_entry.instr <= misaligned ? NOP_INSTR : mem[word_idx];
            pend_entry.err   <= misaligned;
        end
    end

    resp_fifo2 u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (pend_valid),
        .pop   (pop),
        .din   (pend_entry),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign resp_valid = !fifo_empty;
    assign resp_instr = head.instr;
    assign resp_err   = head.err;

endmodule

// File: doc/instr_mem_resp.md
# instr_mem_resp

Instruction-memory responder for the RISC-V core: the read side of the fetch interface driven by the program counter. It accepts byte-address fetch requests over a valid/ready handshake and reads the addressed 32-bit word from a synchronous word array. It returns the word in order through a 2-entry response FIFO, also on valid/ready. A load port fills the array before or between fetches.

## Interface
Parameters:
- alen, 6, byte-address width; must match the PC width
- ilen, 32, instruction width in bits
- depth, 2**(alen-2), number of words in the array

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  1  fetch request present
- req_ready  output  1  request will be accepted this cycle
- req_addr  input  alen  byte address of the instruction
- resp_valid  output  1  FIFO head holds a response
- resp_ready  input  1  consumer takes the head this cycle
- resp_instr  output  ilen  instruction at the FIFO head
- resp_err  output  1  head response came from a misaligned request
- ld_en  input  1  write one word into the array
- ld_addr  input  alen-2  word index to write
- ld_data  input  ilen  word to write

## Operation
- Request accept: req_valid && req_ready at a rising edge.
- Word index: req_addr[alen-1:2]. Misaligned means req_addr[1:0] != 0.
- Read stage, one-entry pending register:
  - On accept, the array word is read and captured with the misaligned flag; pending = 1.
  - The next edge pushes the pending entry into the FIFO.
  - A misaligned request does not use the array read. It pushes instr = 32'h00000013 (NOP) with err = 1.
- Response FIFO:
  - 2 entries, strictly in order. count ranges 0..2.
  - Pop on resp_valid && resp_ready. Push from pending. Push and pop in the same cycle both take effect.
- req_ready = !ld_en && ((count + pending < 2) || (resp_valid && resp_ready)). This depends combinationally on resp_ready, which sustains one request per cycle.
- Load port: when ld_en = 1, mem[ld_addr] <= ld_data at the edge. req_ready is forced low that cycle, so load always wins over fetch.
- Requests already pending when a load arrives keep their pre-load read data.
- Array contents are not reset. Unloaded words read as X in simulation.
- Any address within alen bits is legal. All depth words are addressable, with no wrap or bounds error.

## Timing
- Reset (asynchronous, effective immediately):
  - pending = 0, count = 0, FIFO pointers = 0.
  - resp_valid = 0, resp_instr = 0, resp_err = 0, req_ready = 1 (if ld_en = 0).
- Reset mid-operation discards pending and queued responses. Array contents are preserved.
- Latency: a request accepted at edge N with an empty FIFO gives resp_valid = 1 after edge N+1.
- Throughput: one response per cycle while resp_ready = 1 and ld_en = 0.
- Backpressure:
  - With resp_ready = 0, at most 2 requests are accepted after the FIFO empties (pending + FIFO ≤ 2).
  - req_ready drops as soon as count + pending = 2.
- resp_instr and resp_err are valid only when resp_valid = 1. They are driven from the FIFO head register, not combinationally from the array.
- Full FIFO with pending = 1 cannot occur.

## Structure
- Shared package riscv_pkg:
  - ILEN = 32
  - NOP_INSTR = 32'h00000013
  - typedef resp_t = struct {logic [ILEN-1:0] instr; logic err;}
- Sub-module resp_fifo2: a 2-entry FIFO of resp_t.
  - Ports: push, pop, din, dout, count, empty, full.
  - Async reset clears pointers and count only.
- Top level holds the array, the load write, the pending register and the ready logic.

## Test plan
- Load mem[0..3] = 0xA0,0xA1,0xA2,0xA3. Then request addresses 0,4,8,12 back-to-back with resp_ready = 1 -> 4 consecutive responses 0xA0..0xA3, the first one cycle after the first accept, req_ready held at 1.
- resp_ready = 0, continuous req_valid -> exactly 2 accepts, then req_ready = 0. Raise resp_ready -> responses arrive in order and req_ready returns in the same cycle.
- Request address 6 -> resp_instr = 0x00000013, resp_err = 1. Next request to address 8 -> resp_err = 0 with the correct word.
- ld_en = 1 together with req_valid -> req_ready = 0, no accept. mem[ld_addr] updated and readable on a request the next cycle.
- Assert reset with 2 responses queued -> resp_valid = 0 immediately. After release, a request to address 0 returns the previously loaded 0xA0.
- Request address 60 (word 15) with alen = 6 -> the word loaded at index 15 is returned, err = 0.
